// File: rtl/comparator_serial_if.sv
// comparator_serial_if
//   Request/result bundle for the serial magnitude comparator.
//   Handshake: the requester raises start with A, B and signed_mode valid; the
//   comparator takes them on the first rising edge where it is idle (busy=0)
//   and ignores start while busy. Completion is a one-cycle done pulse; the
//   result flags are valid from that cycle and held until the next accepted
//   start clears them.
//   Ports (master = requester, slave = comparator):
//     start, signed_mode, A, B              master -> slave
//     busy, done, A_greater_B, A_equal_B,
//     A_less_B                              slave -> master
interface comparator_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_greater_B;
    logic             A_equal_B;
    logic             A_less_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_greater_B, A_equal_B, A_less_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_greater_B, A_equal_B, A_less_B
    );
endinterface

// File: rtl/comparator_serial.sv
// comparator_serial
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands CHUNK
//   bits per clock, most-significant chunk first, stopping at the first chunk
//   that differs. Signed mode flips the operand sign bits on the first chunk,
//   which turns the unsigned chunk compare into a two's-complement compare.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        comparator_serial_if.slave (start/operands in, busy/done/flags out)
//     dbg_state  current FSM state (0 = IDLE, 1 = RUN)
module comparator_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    comparator_serial_if.slave  bus,
    output logic                dbg_state
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    // The captured operands are shifted left one chunk per equal compare, so
    // the chunk under test always sits in the top CHUNK bits.
    logic [CHUNK-1:0] chunk_a, chunk_b;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        chunk_a = a_q[WIDTH-1 -: CHUNK];
        chunk_b = b_q[WIDTH-1 -: CHUNK];
        // Inverting both sign bits maps two's-complement order onto unsigned
        // order; only the first chunk carries the sign bit.
        if (sgn_q && (idx_q == '0)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sgn_d   = bus.signed_mode;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (chunk_a != chunk_b) begin
                    gt_d    = (chunk_a > chunk_b);
                    lt_d    = (chunk_a < chunk_b);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == IDX_W'(N - 1)) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.A_greater_B = gt_q;
    assign bus.A_equal_B   = eq_q;
    assign bus.A_less_B    = lt_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_comparator_serial.sv
module tb_comparator_serial;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    logic dbg_state;

    comparator_serial_if #(.WIDTH(WIDTH)) bus ();

    comparator_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];     // expected {gt, eq, lt}
    int         lat_q[$];     // expected cycles from accepting edge to done
    logic [2:0] last_flags;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {bus.A_greater_B, bus.A_equal_B, bus.A_less_B};
    endfunction

    // Reference model: whole-word arithmetic compare; latency is the position
    // of the first differing chunk counted from the top, or N if all equal.
    function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b001;
            return 3'b010;
        end
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] a, b);
        logic [WIDTH-1:0] diff;
        diff = a ^ b;
        for (int i = 0; i < N; i++) begin
            if ((diff >> (WIDTH - CHUNK * (i + 1))) % (1 << CHUNK) != 0) return i + 1;
        end
        return N;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; start is accepted at the following rising edge
    // and the task returns at the falling edge after it (first RUN cycle).
    task automatic issue(input logic [WIDTH-1:0] a, b, input logic s);
        bus.A           = a;
        bus.B           = b;
        bus.signed_mode = s;
        bus.start       = 1'b1;
        exp_q.push_back(ref_flags(a, b, s));
        lat_q.push_back(ref_lat(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; start_cyc is how many RUN cycles have already
    // elapsed when called. Returns at the falling edge where done is high.
    task automatic wait_done(input int start_cyc);
        int         cyc;
        logic [2:0] ef;
        int         el;
        cyc = start_cyc;
        while (bus.done !== 1'b1 && cyc < N + 3) begin
            check("busy_run", bus.busy, 1);
            check("flags_clr", flags_now(), 0);
            check("state_run", dbg_state, 1);
            @(negedge clk);
            cyc++;
        end
        ef = exp_q.pop_front();
        el = lat_q.pop_front();
        check("done_seen", bus.done, 1);
        check("latency", cyc, el);
        check("flags", flags_now(), ef);
        check("busy_off", bus.busy, 0);
        last_flags = ef;
    endtask

    // One cycle after done: pulse gone, flags held.
    task automatic after_done();
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("flags_hold", flags_now(), last_flags);
    endtask

    task automatic run_one(input logic [WIDTH-1:0] a, b, input logic s);
        issue(a, b, s);
        wait_done(0);
        after_done();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               mode;

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        last_flags      = '0;

        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", flags_now(), 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal operands, full latency
        run_one(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        // Early exit, unsigned then signed
        run_one(32'h81000000, 32'h7FFFFFFF, 1'b0);
        run_one(32'h81000000, 32'h7FFFFFFF, 1'b1);
        // Last-chunk differences
        run_one(32'h12345678, 32'h12345679, 1'b0);
        run_one(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);

        // Start during RUN is ignored
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        bus.A     = 32'h1;
        bus.B     = 32'h0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1);
        after_done();
        for (int i = 0; i < N + 2; i++) begin
            check("no_second_done", bus.done, 0);
            @(negedge clk);
        end

        // Reset in the second RUN cycle aborts the compare
        issue(32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_flags", flags_now(), 0);
        check("abort_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("post_rst_done", bus.done, 0);
            check("post_rst_busy", bus.busy, 0);
        end

        // Back-to-back: new start presented in the done cycle
        issue(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        wait_done(0);
        issue(32'd5, 32'd9, 1'b0);
        wait_done(0);
        after_done();

        // Randomized compares
        for (int k = 0; k < 150; k++) begin
            ra   = $urandom();
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                2:       rb = $urandom();
                default: rb = (ra & ~((WIDTH'(1) << $urandom_range(1, WIDTH - 1)) - 1))
                              | ($urandom() & ((WIDTH'(1) << $urandom_range(1, WIDTH - 1)) - 1));
            endcase
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                issue(ra, rb, rs);
                wait_done(0);
                after_done();
            end else begin
                run_one(rb, ra, rs);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
